wave_capture_render: RTL and testbench
======================================

// Module: wave_capture_render
// PURPOSE
//  Upstream stage of the VGA timing/grid block: captures ADC samples into ping-pong line buffers on a
//  level trigger and renders the stored trace per pixel from xCount/yCount. trace_on is OR-ed with
//  the grid green. Single clock domain clk; pixel rate via pix_en strobe (VGA_clk rate, clk/2).
// PARAMETERS
//  SAMPLE_W    8    ADC sample width
//  DEPTH       640  samples per capture = visible columns
//  WAVE_ROWS   384  waveform area rows (0..383)
//  VBLANK_ROW  480  row where bank swap is allowed
//  AUTO_FRAMES 4    frames armed without trigger before forced capture (auto mode)
// PORTS
//  clk        in   1   system clock (same clk that drives the VGA divider)
//  rst        in   1   synchronous reset, active-high
//  pix_en     in   1   one-clk strobe per VGA pixel; xCount/yCount valid when high
//  xCount     in   10  pixel column from VGA timing
//  yCount     in   10  pixel row from VGA timing
//  sample_en  in   1   one-clk strobe: sample valid
//  sample     in   8   unsigned ADC sample
//  trig_level in   8   trigger threshold
//  auto_mode  in   1   1 = force capture after AUTO_FRAMES
//  run_cont   in   1   1 = re-arm automatically after each swap
//  arm        in   1   one-clk pulse: start single acquisition from IDLE
//  trace_on   out  1   pixel belongs to trace (registered)
//  armed      out  1   state == ARMED
//  capturing  out  1   state == CAPTURE
//  frame_rdy  out  1   one-clk pulse on bank swap
// BEHAVIOUR
//  Reset: state IDLE, wr_bank=0, disp_valid=0, all outputs 0, addr/frame counters 0.
//  FSM (advances on clk; sample logic qualified by sample_en, frame logic by pix_en):
//   IDLE    -> ARMED when arm=1 or run_cont=1.
//   ARMED   -> CAPTURE on rising crossing: prev_sample < trig_level && sample >= trig_level (at sample_en);
//              also -> CAPTURE when auto_mode=1 and AUTO_FRAMES frame starts (x=0,y=0) seen while armed.
//              Triggering sample is written at addr 0.
//   CAPTURE -> each sample_en writes sample to wr_bank[addr], addr++; after write at DEPTH-1 -> PENDING.
//   PENDING -> at pix_en with yCount==VBLANK_ROW && xCount==0: swap banks, disp_valid=1, frame_rdy pulse;
//              -> ARMED if run_cont else IDLE.
//  prev_sample updates on every sample_en in every state; frame counter clears on entering ARMED.
//  arm while not IDLE: ignored. run_cont deasserted mid-capture: current capture completes, then IDLE.
//  Swap only in vblank: displayed bank never changes mid-frame (no tearing).
//  Write and read always target different banks; simultaneous sample_en and pix_en are legal.
//  Row mapping: row(s) = 383 - (s + (s>>1)), 9-bit unsigned; s=0 -> 383, s=255 -> 1.
//  Render pipeline (pix_en-qualified): P1 read disp_bank[xCount] (sync RAM) for xCount<DEPTH;
//   P2 cur=row(data), keep prv=row of previous column (prv=cur at xCount==0);
//   trace_on <= disp_valid && y<WAVE_ROWS && x<DEPTH && min(prv,cur) <= y <= max(prv,cur).
//   Latency: trace_on corresponds to (xCount,yCount) presented 2 pix_en strobes earlier; x/y delayed internally.
//  Outside waveform area, or disp_valid=0: trace_on=0. rst mid-capture: discard, disp_valid=0.
// STRUCTURE
//  Package wave_pkg: SAMPLE_W, DEPTH, WAVE_ROWS, VBLANK_ROW, state enum {IDLE,ARMED,CAPTURE,PENDING},
//   row-mapping function.
//  Sub-module wave_line_ram: 2xDEPTH x SAMPLE_W, one write port (bank, addr), one sync read port.
// TESTING
//  1 rst, run_cont=0, arm pulse, samples ramp 0..255 repeat, level=128 -> CAPTURE starts at sample 128;
//    addr 0 holds 128; after 640 samples PENDING; frame_rdy exactly at y=480,x=0.
//  2 constant sample 50, auto_mode=1, level=200 -> forced capture after 4 frame starts; rendered row
//    308 on every column; trace_on=1 only at y=308.
//  3 auto_mode=0, no crossing -> stays ARMED indefinitely, trace_on remains 0 (disp_valid=0).
//  4 run_cont=1, step 0 -> 255 between column 99 and 100 -> column 100 lit for y=1..383;
//    continuous captures swap every qualifying frame.
//  5 capture completes at y=200 -> displayed bank unchanged until y=480; rows 200-479 match old data.
//  6 rst asserted mid-CAPTURE (addr=300) -> next clk IDLE, all outputs 0, trace_on 0 next frame.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared parameters, FSM state type and sample-to-row mapping
// for the waveform capture/render block.
package wave_pkg;

   localparam int SAMPLE_W    = 8;
   localparam int DEPTH       = 640;
   localparam int WAVE_ROWS   = 384;
   localparam int VBLANK_ROW  = 480;
   localparam int AUTO_FRAMES = 4;
   localparam int AW          = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE,
      PENDING
   } state_e;

   // row(s) = 383 - (s + s/2): full scale spans rows 383..1
   function automatic logic [8:0] row_of(
      input logic [SAMPLE_W-1:0] s
   );
      logic [8:0] sum;
      sum = {1'b0, s} + {2'b00, s[SAMPLE_W-1:1]};
      return 9'(WAVE_ROWS - 1) - sum;
   endfunction

endpackage

// File: rtl/wave_line_ram.sv
// Ping-pong line store: two banks of DEPTH samples.
// Ports: clk_i; write we_i/wr_bank_i/wr_addr_i/wr_data_i;
//        sync read re_i/rd_bank_i/rd_addr_i -> rd_data_o (1 clk).
module wave_line_ram
   import wave_pkg::*;
(
   input  logic                clk_i,
   input  logic                we_i,
   input  logic                wr_bank_i,
   input  logic [AW-1:0]       wr_addr_i,
   input  logic [SAMPLE_W-1:0] wr_data_i,
   input  logic                re_i,
   input  logic                rd_bank_i,
   input  logic [AW-1:0]       rd_addr_i,
   output logic [SAMPLE_W-1:0] rd_data_o
);

   logic [SAMPLE_W-1:0] mem_q [2*DEPTH];
   logic [SAMPLE_W-1:0] rd_data_q;
   logic [AW:0]         wr_idx;
   logic [AW:0]         rd_idx;

   // bank 1 occupies the upper DEPTH entries
   assign wr_idx = wr_bank_i ? (AW+1)'(DEPTH) + {1'b0, wr_addr_i}
                             : {1'b0, wr_addr_i};
   assign rd_idx = rd_bank_i ? (AW+1)'(DEPTH) + {1'b0, rd_addr_i}
                             : {1'b0, rd_addr_i};

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[wr_idx] <= wr_data_i;
      if (re_i) rd_data_q <= mem_q[rd_idx];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/wave_capture_render.sv
// Triggered ADC line capture into ping-pong banks and per-pixel trace render.
// Ports: clk, rst (sync, high), pix_en/xCount/yCount pixel strobe, sample_en/sample,
//        trig_level, auto_mode, run_cont, arm; out trace_on, armed, capturing, frame_rdy.
module wave_capture_render
   import wave_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                pix_en,
   input  logic [9:0]          xCount,
   input  logic [9:0]          yCount,
   input  logic                sample_en,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [SAMPLE_W-1:0] trig_level,
   input  logic                auto_mode,
   input  logic                run_cont,
   input  logic                arm,
   output logic                trace_on,
   output logic                armed,
   output logic                capturing,
   output logic                frame_rdy
);

   state_e              state_q, state_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic                wr_bank_q, wr_bank_d;
   logic                disp_valid_q, disp_valid_d;
   logic [2:0]          frm_q, frm_d;
   logic                frame_rdy_q, frame_rdy_d;
   logic [SAMPLE_W-1:0] prev_q;

   logic trig;
   logic frame_start;
   logic vblank;
   logic we;

   assign trig = sample_en && (prev_q < trig_level)
              && (sample >= trig_level);
   assign frame_start = pix_en && (xCount == '0)
                     && (yCount == '0);
   assign vblank = pix_en && (xCount == '0)
                && (yCount == 10'(VBLANK_ROW));

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wr_bank_d    = wr_bank_q;
      disp_valid_d = disp_valid_q;
      frm_d        = frm_q;
      frame_rdy_d  = 1'b0;
      we           = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arm || run_cont) begin
               state_d = ARMED;
               addr_d  = '0;
               frm_d   = '0;
            end
         end
         ARMED: begin
            // the triggering sample itself lands at addr 0
            if (trig) begin
               we      = 1'b1;
               addr_d  = AW'(1);
               state_d = CAPTURE;
            end else if (auto_mode && frame_start) begin
               if (frm_q == 3'(AUTO_FRAMES - 1)) begin
                  addr_d  = '0;
                  state_d = CAPTURE;
               end else begin
                  frm_d = frm_q + 3'd1;
               end
            end
         end
         CAPTURE: begin
            if (sample_en) begin
               we = 1'b1;
               if (addr_q == AW'(DEPTH - 1)) begin
                  addr_d  = '0;
                  state_d = PENDING;
               end else begin
                  addr_d = addr_q + AW'(1);
               end
            end
         end
         PENDING: begin
            // swap only in vblank so a frame never tears
            if (vblank) begin
               wr_bank_d    = ~wr_bank_q;
               disp_valid_d = 1'b1;
               frame_rdy_d  = 1'b1;
               frm_d        = '0;
               state_d      = run_cont ? ARMED : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wr_bank_q    <= 1'b0;
         disp_valid_q <= 1'b0;
         frm_q        <= '0;
         frame_rdy_q  <= 1'b0;
         prev_q       <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wr_bank_q    <= wr_bank_d;
         disp_valid_q <= disp_valid_d;
         frm_q        <= frm_d;
         frame_rdy_q  <= frame_rdy_d;
         if (sample_en) prev_q <= sample;
      end
   end

   assign armed     = (state_q == ARMED);
   assign capturing = (state_q == CAPTURE);
   assign frame_rdy = frame_rdy_q;

   // render: P1 reads the display bank, P2 forms the column span
   logic [SAMPLE_W-1:0] rd_data;
   logic                re;
   logic [9:0]          x1_q, y1_q;
   logic [8:0]          prv_q;
   logic                trace_q;
   logic [8:0]          cur;
   logic [8:0]          prv;
   logic [8:0]          lo, hi;
   logic                hit;

   assign re = pix_en && (xCount < 10'(DEPTH));

   wave_line_ram u_ram (
      .clk_i     (clk),
      .we_i      (we),
      .wr_bank_i (wr_bank_q),
      .wr_addr_i (addr_q),
      .wr_data_i (sample),
      .re_i      (re),
      .rd_bank_i (~wr_bank_q),
      .rd_addr_i (xCount[AW-1:0]),
      .rd_data_o (rd_data)
   );

   always_comb begin
      cur = row_of(rd_data);
      // first column has no left neighbour: draw a single point
      prv = (x1_q == '0) ? cur : prv_q;
      lo  = (cur < prv) ? cur : prv;
      hi  = (cur < prv) ? prv : cur;
      hit = disp_valid_q
         && (y1_q < 10'(WAVE_ROWS))
         && (x1_q < 10'(DEPTH))
         && ({1'b0, lo} <= y1_q)
         && (y1_q <= {1'b0, hi});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x1_q    <= '0;
         y1_q    <= '0;
         prv_q   <= '0;
         trace_q <= 1'b0;
      end else if (pix_en) begin
         x1_q    <= xCount;
         y1_q    <= yCount;
         prv_q   <= cur;
         trace_q <= hit;
      end
   end

   assign trace_on = trace_q;

endmodule

// File: tb/tb_wave_capture_render.sv
// Self-checking bench for wave_capture_render: sparse pixel
// strobes, sample streams, and a column/row reference model.
module tb_wave_capture_render;

   logic       clk = 1'b0;
   logic       rst;
   logic       pix_en;
   logic [9:0] xCount;
   logic [9:0] yCount;
   logic       sample_en;
   logic [7:0] sample;
   logic [7:0] trig_level;
   logic       auto_mode;
   logic       run_cont;
   logic       arm;
   logic       trace_on;
   logic       armed;
   logic       capturing;
   logic       frame_rdy;

   wave_capture_render dut (
      .clk        (clk),
      .rst        (rst),
      .pix_en     (pix_en),
      .xCount     (xCount),
      .yCount     (yCount),
      .sample_en  (sample_en),
      .sample     (sample),
      .trig_level (trig_level),
      .auto_mode  (auto_mode),
      .run_cont   (run_cont),
      .arm        (arm),
      .trace_on   (trace_on),
      .armed      (armed),
      .capturing  (capturing),
      .frame_rdy  (frame_rdy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int fr_cnt = 0;
   int fr_x   = -1;
   int fr_y   = -1;
   int feed_q[$];
   int last_s = 0;
   int cap[640];
   int disp[640];
   bit dv = 0;

   function automatic int row_m(int s);
      return 383 - (s + s / 2);
   endfunction

   function automatic int find_trig(int p, int lvl, int st[$]);
      for (int i = 0; i < st.size(); i++) begin
         if (p < lvl && st[i] >= lvl) return i;
         p = st[i];
      end
      return -1;
   endfunction

   task automatic load_cap(int st[$], int t);
      for (int i = 0; i < 640; i++) cap[i] = st[t + i];
   endtask

   task automatic feed(int st[$]);
      foreach (st[i]) feed_q.push_back(st[i]);
      if (st.size() > 0) last_s = st[st.size() - 1];
   endtask

   task automatic tick();
      if (feed_q.size() > 0) begin
         sample_en = 1'b1;
         sample    = 8'(feed_q.pop_front());
      end else begin
         sample_en = 1'b0;
      end
      @(posedge clk);
      #1;
      if (frame_rdy === 1'b1) begin
         fr_cnt++;
         fr_x = int'(xCount);
         fr_y = int'(yCount);
      end
   endtask

   task automatic strobe(int x, int y);
      xCount = 10'(x);
      yCount = 10'(y);
      pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      tick();
   endtask

   task automatic drain();
      int guard = 0;
      while (feed_q.size() > 0 && guard < 5000) begin
         tick();
         guard++;
      end
      tick();
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_reset();
      feed_q.delete();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      dv = 0;
      last_s = 0;
      tick();
   endtask

   task automatic scan_row(int y);
      logic obs[640];
      int bad = 0;
      int first = -1;
      logic fo = 1'b0;
      logic fe = 1'b0;
      for (int n = 0; n < 642; n++) begin
         xCount = 10'(n);
         yCount = 10'(y);
         pix_en = 1'b1;
         if (n >= 2) obs[n - 2] = trace_on;
         tick();
         pix_en = 1'b0;
         tick();
      end
      for (int x = 0; x < 640; x++) begin
         int c, p, lo, hi;
         logic e;
         c  = row_m(disp[x]);
         p  = (x == 0) ? c : row_m(disp[x - 1]);
         lo = (c < p) ? c : p;
         hi = (c < p) ? p : c;
         e  = dv && y < 384 && y >= lo && y <= hi;
         if (obs[x] !== e) begin
            if (first < 0) begin
               first = x;
               fo = obs[x];
               fe = e;
            end
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL scan_row y=%0d: %0d cols differ, col %0d got %b expected %b",
                  y, bad, first, fo, fe);
      end
   endtask

   task automatic do_swap(bit exp_swap);
      int f0 = fr_cnt;
      strobe(0, 480);
      tick();
      checks++;
      if (fr_cnt !== f0 + int'(exp_swap)) begin
         errors++;
         $display("FAIL frame_rdy count: got %0d expected %0d",
                  fr_cnt - f0, int'(exp_swap));
      end
      if (exp_swap) begin
         checks++;
         if (fr_x !== 0 || fr_y !== 480) begin
            errors++;
            $display("FAIL frame_rdy position: got x=%0d y=%0d expected x=0 y=480",
                     fr_x, fr_y);
         end
         disp = cap;
         dv = 1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({armed, capturing, frame_rdy, trace_on} !== 4'b0000) begin
         errors++;
         $display("FAIL reset outputs: got %b expected 0000",
                  {armed, capturing, frame_rdy, trace_on});
      end
   endtask

   task automatic test_trigger();
      int st[$];
      int a[$];
      int t;
      trig_level = 8'd128;
      pulse_arm();
      checks++;
      if (armed !== 1'b1) begin
         errors++;
         $display("FAIL arm: armed got %b expected 1", armed);
      end
      for (int k = 0; k < 768; k++) st.push_back(k % 256);
      t = find_trig(last_s, 128, st);
      load_cap(st, t);
      a = st[0:t-1];
      feed(a);
      drain();
      checks++;
      if ({armed, capturing} !== 2'b10) begin
         errors++;
         $display("FAIL pre-trigger: armed,capturing got %b expected 10",
                  {armed, capturing});
      end
      a = st[t:t];
      feed(a);
      drain();
      checks++;
      if ({armed, capturing} !== 2'b01) begin
         errors++;
         $display("FAIL trigger: armed,capturing got %b expected 01",
                  {armed, capturing});
      end
      a = st[t+1:t+639];
      feed(a);
      drain();
      checks++;
      if ({armed, capturing} !== 2'b00) begin
         errors++;
         $display("FAIL pending: armed,capturing got %b expected 00",
                  {armed, capturing});
      end
      do_swap(1);
      checks++;
      if (armed !== 1'b0) begin
         errors++;
         $display("FAIL single-shot idle: armed got %b expected 0", armed);
      end
      scan_row(row_m(128));
      scan_row(0);
      scan_row(383);
      scan_row($urandom_range(1, 382));
      scan_row(420);
   endtask

   task automatic test_auto();
      int st[$];
      trig_level = 8'd200;
      auto_mode  = 1'b1;
      st = '{50};
      feed(st);
      drain();
      pulse_arm();
      for (int f = 1; f <= 4; f++) begin
         strobe(0, 0);
         checks++;
         if (capturing !== (f == 4)) begin
            errors++;
            $display("FAIL auto frame %0d: capturing got %b expected %b",
                     f, capturing, (f == 4));
         end
      end
      st.delete();
      for (int k = 0; k < 640; k++) st.push_back(50);
      load_cap(st, 0);
      feed(st);
      drain();
      auto_mode = 1'b0;
      do_swap(1);
      scan_row(308);
      scan_row(307);
      scan_row(309);
      scan_row($urandom_range(0, 383));
   endtask

   task automatic test_no_trigger();
      int st[$];
      do_reset();
      trig_level = 8'd200;
      pulse_arm();
      for (int k = 0; k < 300; k++) st.push_back($urandom_range(0, 199));
      feed(st);
      drain();
      for (int f = 0; f < 6; f++) strobe(0, 0);
      checks++;
      if ({armed, capturing} !== 2'b10) begin
         errors++;
         $display("FAIL no-trigger: armed,capturing got %b expected 10",
                  {armed, capturing});
      end
      scan_row(100);
      scan_row($urandom_range(0, 383));
   endtask

   task automatic test_continuous();
      int st[$];
      int t, lvl;
      do_reset();
      run_cont  = 1'b1;
      auto_mode = 1'b1;
      tick();
      for (int f = 0; f < 4; f++) strobe(0, 0);
      checks++;
      if (capturing !== 1'b1) begin
         errors++;
         $display("FAIL cont forced: capturing got %b expected 1", capturing);
      end
      auto_mode = 1'b0;
      for (int k = 0; k < 640; k++) st.push_back(k < 100 ? 0 : 255);
      load_cap(st, 0);
      feed(st);
      drain();
      do_swap(1);
      checks++;
      if (armed !== 1'b1) begin
         errors++;
         $display("FAIL cont re-arm: armed got %b expected 1", armed);
      end
      scan_row(0);
      scan_row(1);
      scan_row(2);
      scan_row(200);
      scan_row(383);
      lvl = $urandom_range(1, 255);
      trig_level = 8'(lvl);
      st.delete();
      st.push_back(lvl - 1);
      st.push_back($urandom_range(lvl, 255));
      for (int k = 0; k < 639; k++) st.push_back($urandom_range(0, 255));
      t = find_trig(last_s, lvl, st);
      load_cap(st, t);
      feed(st);
      drain();
      do_swap(1);
      scan_row(row_m(cap[0]));
      scan_row($urandom_range(0, 383));
      scan_row($urandom_range(0, 383));
      do_swap(0);
      scan_row($urandom_range(0, 383));
   endtask

   task automatic test_no_tearing();
      int st[$];
      int t, lvl, f0;
      lvl = $urandom_range(1, 255);
      trig_level = 8'(lvl);
      st.push_back(lvl - 1);
      st.push_back($urandom_range(lvl, 255));
      for (int k = 0; k < 639; k++) st.push_back($urandom_range(0, 255));
      t = find_trig(last_s, lvl, st);
      load_cap(st, t);
      f0 = fr_cnt;
      feed(st);
      scan_row(200);
      checks++;
      if ({armed, capturing} !== 2'b00) begin
         errors++;
         $display("FAIL mid-frame pending: armed,capturing got %b expected 00",
                  {armed, capturing});
      end
      scan_row(300);
      scan_row(383);
      checks++;
      if (fr_cnt !== f0) begin
         errors++;
         $display("FAIL early swap: frame_rdy pulses got %0d expected 0",
                  fr_cnt - f0);
      end
      do_swap(1);
      scan_row(200);
      scan_row($urandom_range(0, 383));
   endtask

   task automatic test_reset_mid();
      int st[$];
      int lvl;
      run_cont = 1'b0;
      lvl = $urandom_range(1, 255);
      trig_level = 8'(lvl);
      st.push_back(lvl - 1);
      st.push_back($urandom_range(lvl, 255));
      for (int k = 0; k < 299; k++) st.push_back($urandom_range(0, 255));
      feed(st);
      drain();
      checks++;
      if (capturing !== 1'b1) begin
         errors++;
         $display("FAIL mid-capture: capturing got %b expected 1", capturing);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({armed, capturing, frame_rdy, trace_on} !== 4'b0000) begin
         errors++;
         $display("FAIL reset mid-capture: outputs got %b expected 0000",
                  {armed, capturing, frame_rdy, trace_on});
      end
      rst = 1'b0;
      dv = 0;
      last_s = 0;
      tick();
      scan_row(row_m(disp[0]));
      scan_row($urandom_range(0, 383));
      do_swap(0);
   endtask

   initial begin
      rst        = 1'b1;
      pix_en     = 1'b0;
      xCount     = '0;
      yCount     = '0;
      sample_en  = 1'b0;
      sample     = '0;
      trig_level = '0;
      auto_mode  = 1'b0;
      run_cont   = 1'b0;
      arm        = 1'b0;
      test_reset();
      test_trigger();
      test_auto();
      test_no_trigger();
      test_continuous();
      test_no_tearing();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
